fc_result_reader: RTL

Reads the final-layer class scores that the fully-connected output stage has written into the shared result BRAM, determines the winning class, and transmits the scores plus the class index as a byte stream. Sits after the FC2 stage in the LeNet pipeline and is started by the top-level sequencer once FC2 reports completion. It is the consumer side of the result-BRAM region that FC2 fills.

---
 rtl/fc_result_reader_pkg.sv | 35 +++
 rtl/fc_result_reader_argmax_step.sv | 20 ++
 rtl/fc_result_reader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fc_result_reader_pkg.sv
// Shared LeNet output-layer constants: result-BRAM layout, score format,
// BRAM read latency and the result reader's one-hot state encoding.
package fc_result_reader_pkg;

  localparam int FC2_RESULT_BASE = 18900;
  localparam int RESULT_BASE     = FC2_RESULT_BASE;
  localparam int NUM_CLASSES     = 10;
  localparam int DATA_SIZE       = 8;
  localparam int READ_LAT        = 3;

  localparam int ADDR_W  = 15;
  localparam int IDX_W   = 4;
  localparam int STATE_W = 6;

  localparam logic [ADDR_W-1:0] RESULT_ADDR = ADDR_W'(RESULT_BASE);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0]  NCLS        = IDX_W'(NUM_CLASSES);
  localparam logic [IDX_W-1:0]  END_CNT     = IDX_W'(NUM_CLASSES + 1);
  localparam logic [1:0]        WAIT_LAST   = 2'(READ_LAT - 2);

  localparam logic signed [DATA_SIZE-1:0] MIN_SCORE = {1'b1, {(DATA_SIZE-1){1'b0}}};

  localparam logic [STATE_W-1:0] S_IDLE         = 6'b000001;
  localparam logic [STATE_W-1:0] S_READ_ISSUE   = 6'b000010;
  localparam logic [STATE_W-1:0] S_READ_WAIT    = 6'b000100;
  localparam logic [STATE_W-1:0] S_READ_CAPTURE = 6'b001000;
  localparam logic [STATE_W-1:0] S_SEND         = 6'b010000;
  localparam logic [STATE_W-1:0] S_DONE         = 6'b100000;

  // Trailer byte of the stream: class index zero-extended to a byte.
  function automatic logic [7:0] class_byte(input logic [IDX_W-1:0] idx);
    return {{(8-IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/fc_result_reader_argmax_step.sv
// One step of a running signed argmax; strict compare so the earliest
// index keeps the win on ties.
module signed_argmax_step
  import fc_result_reader_pkg::*;
(
  input  logic signed [DATA_SIZE-1:0] cand,
  input  logic        [IDX_W-1:0]     cand_idx,
  input  logic signed [DATA_SIZE-1:0] cur_max,
  input  logic        [IDX_W-1:0]     cur_idx,
  output logic signed [DATA_SIZE-1:0] new_max,
  output logic        [IDX_W-1:0]     new_idx
);

  logic take;

  assign take    = cand > cur_max;
  assign new_max = take ? cand : cur_max;
  assign new_idx = take ? cand_idx : cur_idx;

endmodule

// File: rtl/fc_result_reader.sv
// Reads the FC2 class scores from the result BRAM, tracks the argmax and
// streams the scores followed by the winning class index.
module fc_result_reader
  import fc_result_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reader_en,
  input  logic [DATA_SIZE-1:0] result_bram_douta,
  output logic                 result_bram_ena,
  output logic [ADDR_W-1:0]    result_bram_addra,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [IDX_W-1:0]     class_idx,
  output logic                 class_valid,
  output logic                 reader_finish
);

  logic [STATE_W-1:0]          state;
  logic [IDX_W-1:0]            counter;
  logic [IDX_W-1:0]            byte_cnt;
  logic [1:0]                  wait_cnt;
  logic signed [DATA_SIZE-1:0] run_max;
  logic [IDX_W-1:0]            run_idx;
  logic signed [DATA_SIZE-1:0] next_max;
  logic [IDX_W-1:0]            next_idx;
  logic [DATA_SIZE-1:0]        score_buf [0:(1<<IDX_W)-1];
  logic                        hs;
  logic [IDX_W-1:0]            sel;
  logic [7:0]                  next_byte;

  signed_argmax_step u_step (
    .cand     (result_bram_douta),
    .cand_idx (counter),
    .cur_max  (run_max),
    .cur_idx  (run_idx),
    .new_max  (next_max),
    .new_idx  (next_idx)
  );

  assign hs = tx_valid & tx_ready;

  // After a handshake the following byte is prepared; otherwise the current one.
  always_comb begin
    sel       = hs ? byte_cnt + IDX_W'(1) : byte_cnt;
    next_byte = class_byte(class_idx);
    if (sel < NCLS) next_byte = score_buf[sel];
  end

  always_ff @(posedge clk) begin
    if (state == S_READ_CAPTURE && reader_en) score_buf[counter] <= result_bram_douta;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      counter           <= '0;
      byte_cnt          <= '0;
      wait_cnt          <= '0;
      run_max           <= MIN_SCORE;
      run_idx           <= '0;
      result_bram_ena   <= 1'b0;
      result_bram_addra <= '0;
      tx_data           <= '0;
      tx_valid          <= 1'b0;
      class_idx         <= '0;
      class_valid       <= 1'b0;
      reader_finish     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (reader_en) begin
            counter           <= '0;
            run_max           <= MIN_SCORE;
            run_idx           <= '0;
            class_valid       <= 1'b0;
            reader_finish     <= 1'b0;
            result_bram_ena   <= 1'b1;
            result_bram_addra <= RESULT_ADDR;
            state             <= S_READ_ISSUE;
          end
        end
        S_READ_ISSUE: begin
          if (reader_en) begin
            wait_cnt <= '0;
            state    <= S_READ_WAIT;
          end
        end
        S_READ_WAIT: begin
          if (reader_en) begin
            if (wait_cnt == WAIT_LAST) state <= S_READ_CAPTURE;
            else                       wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_READ_CAPTURE: begin
          if (reader_en) begin
            run_max <= next_max;
            run_idx <= next_idx;
            if (counter == LAST_IDX) begin
              result_bram_ena <= 1'b0;
              class_idx       <= next_idx;
              class_valid     <= 1'b1;
              counter         <= '0;
              byte_cnt        <= '0;
              tx_valid        <= 1'b1;
              tx_data         <= score_buf[0];
              state           <= S_SEND;
            end else begin
              counter           <= counter + IDX_W'(1);
              result_bram_addra <= result_bram_addra + ADDR_W'(1);
              state             <= S_READ_ISSUE;
            end
          end
        end
        S_SEND: begin
          // A handshake is honoured even while frozen; only the next byte waits.
          if (hs) begin
            byte_cnt <= byte_cnt + IDX_W'(1);
            if (byte_cnt == NCLS) begin
              tx_valid <= 1'b0;
              if (reader_en) begin
                reader_finish <= 1'b1;
                state         <= S_DONE;
              end
            end else begin
              tx_valid <= reader_en;
              if (reader_en) tx_data <= next_byte;
            end
          end else if (!tx_valid && reader_en) begin
            if (byte_cnt == END_CNT) begin
              reader_finish <= 1'b1;
              state         <= S_DONE;
            end else begin
              tx_valid <= 1'b1;
              tx_data  <= next_byte;
            end
          end
        end
        S_DONE: begin
          if (!reader_en) begin
            reader_finish <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
